fft_frame_sched: RTL and testbench
==================================

# fft_frame_sched

Frame-level scheduler for the spectrum-analyzer FFT path. It sits between the sample capture buffer, the FFT datapath and the display/readout consumer. It latches "frame complete" events from capture, launches one FFT per frame, releases the capture buffer once loading ends, and streams the resulting bins out as a magnitude estimate over a valid/ready handshake. It also supervises the FFT with a timeout and counts overrun frames.

## Interface

Parameters:
- BIN_NUM, 512: output bins per frame (half of 1024 samples)
- BIN_W, 9: bin index width, clog2(BIN_NUM)
- DATA_W, 32: FFT result component width, signed
- TIMEOUT_CYC, 16384: maximum cycles from fft_start_o to fft_done_i

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- enable_i  in  1  run enable; when low, no new FFT is launched
- frame_new_i  in  1  1-cycle pulse from capture: a full frame is available
- frame_ack_o  out  1  1-cycle pulse: capture buffer may be overwritten
- fft_start_o  out  1  1-cycle pulse that launches the FFT
- fft_loading_i  in  1  high while the FFT reads samples from the buffer
- fft_done_i  in  1  1-cycle pulse: results are valid in the result RAM
- bin_addr_o  out  BIN_W  result RAM read address, read latency 1 cycle
- bin_real_i  in  DATA_W  result real part, signed
- bin_img_i  in  DATA_W  result imaginary part, signed
- out_valid_o  out  1  output bin valid
- out_ready_i  in  1  consumer ready
- out_bin_o  out  BIN_W  bin index of the presented magnitude
- out_mag_o  out  DATA_W+1  |re|+|im|, unsigned
- busy_o  out  1  high in any state other than IDLE
- err_timeout_o  out  1  sticky timeout flag, cleared only by rst
- overrun_cnt_o  out  8  saturating count of dropped frames

## Operation

- pending flag: set by frame_new_i, cleared on entry to START.
  - frame_new_i while pending=1 increments overrun_cnt_o, saturating at 255.
  - frame_new_i in the same cycle as pending is cleared sets pending again with no overrun.
- IDLE: go to START when pending=1 and enable_i=1.
- START: assert fft_start_o for one cycle, clear the timeout counter, then go to LOAD.
- LOAD: wait for fft_loading_i to rise and then fall. On the falling edge, pulse frame_ack_o and go to COMPUTE.
  - If fft_done_i arrives while still in LOAD, pulse frame_ack_o and go directly to READOUT.
- COMPUTE: on fft_done_i, set bin index k=0 and go to RD_ADDR.
- RD_ADDR: drive bin_addr_o=k, then go to RD_DATA.
- RD_DATA: register out_bin_o=k and out_mag_o=abs(re)+abs(im), assert out_valid_o, then go to PRESENT.
  - abs uses a DATA_W+1 intermediate, so abs(-2^31)=2^31 exactly. The sum cannot overflow in DATA_W+1 bits.
- PRESENT: hold all out_* signals stable while out_valid_o=1 and out_ready_i=0. On handshake (valid and ready):
  - if k=BIN_NUM-1, deassert valid and go to IDLE;
  - else increment k and go to RD_ADDR.
- Timeout: the counter runs in LOAD and COMPUTE. When it reaches TIMEOUT_CYC:
  - set err_timeout_o;
  - pulse frame_ack_o if it has not yet been pulsed for this frame;
  - go to IDLE with no readout.
- enable_i low only blocks IDLE to START. A frame already in progress completes.
- fft_done_i or fft_loading_i activity outside LOAD/COMPUTE is ignored.

## Timing

- Reset values:
  - state=IDLE, pending=0, k=0
  - frame_ack_o, fft_start_o, out_valid_o, busy_o = 0
  - bin_addr_o=0, out_bin_o=0, out_mag_o=0
  - err_timeout_o=0, overrun_cnt_o=0
- rst mid-frame aborts immediately: no frame_ack_o, no further outputs.
- frame_new_i at cycle t with the block in IDLE and enabled: fft_start_o at t+2 (t+1 latches pending, t+1 to t+2 is IDLE to START).
- fft_done_i at cycle d: first out_valid_o at d+3.
- Readout throughput is one bin per 3 cycles with out_ready_i held high. A full frame of 512 bins takes 1536 cycles after done.
- frame_ack_o fires in the cycle after the fft_loading_i falling edge is sampled.
- Every output is registered.

## Structure

- Shared package fft_pkg holds:
  - BIN_NUM, BIN_W, DATA_W, TIMEOUT_CYC defaults;
  - the state enum (IDLE, START, LOAD, COMPUTE, RD_ADDR, RD_DATA, PRESENT);
  - an abs_sum function.
- Natural sub-module: fft_mag_est, a combinational abs(re)+abs(im) unit reused later by the display path. Everything else stays in this block.

## Test plan

- Nominal: frame_new_i pulse; model loading for 1024 cycles, then done 500 cycles later.
  - Expect fft_start_o 2 cycles after frame_new_i.
  - Expect frame_ack_o 1 cycle after loading falls.
  - Expect 512 bins, k=0..511 in order, with mag(re=-5, im=7)=12.
- Backpressure: toggle out_ready_i pseudo-randomly.
  - out_bin_o and out_mag_o stay stable while not ready; no bin lost or duplicated.
  - Corner: re=im=-2^31 gives out_mag_o=2^32.
- Overrun: three frame_new_i pulses during COMPUTE. Expect overrun_cnt_o=2 and exactly one further FFT launched afterwards. 300 extra pulses saturate the count at 255.
- Timeout: never pulse fft_done_i. At TIMEOUT_CYC cycles after fft_start_o, expect err_timeout_o=1, state IDLE and no out_valid_o. err_timeout_o stays high across the next good frame.
- enable_i: with enable_i=0, frame_new_i only sets pending and busy_o stays 0. Raising enable_i gives fft_start_o 1 cycle later.
- Reset mid-readout: assert rst at bin 100.
  - Next cycle, all outputs are at reset values.
  - A new frame then starts cleanly from bin 0.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared definitions for the spectrum-analyzer FFT frame path.
package fft_pkg;

    localparam int BIN_NUM     = 512;
    localparam int BIN_W       = 9;
    localparam int DATA_W      = 32;
    localparam int TIMEOUT_CYC = 16384;

    typedef enum logic [2:0] {
        IDLE,
        START,
        LOAD,
        COMPUTE,
        RD_ADDR,
        RD_DATA,
        PRESENT
    } state_t;

    // One extra bit keeps abs(-2^(DATA_W-1)) exact; the sum of two such values still fits.
    function automatic logic [DATA_W:0] abs_sum(input logic signed [DATA_W-1:0] re,
                                                input logic signed [DATA_W-1:0] im);
        logic signed [DATA_W:0] re_x;
        logic signed [DATA_W:0] im_x;
        logic [DATA_W:0]        re_a;
        logic [DATA_W:0]        im_a;
        re_x = re;
        im_x = im;
        re_a = (re_x < 0) ? $unsigned(-re_x) : $unsigned(re_x);
        im_a = (im_x < 0) ? $unsigned(-im_x) : $unsigned(im_x);
        return re_a + im_a;
    endfunction

endpackage

// File: rtl/fft_frame_sched_if.sv
// Magnitude output stream: valid/ready handshake carrying a bin index and |re|+|im|.
interface fft_frame_sched_if
    import fft_pkg::*;
();

    logic              valid;
    logic              ready;
    logic [BIN_W-1:0]  bin;
    logic [DATA_W:0]   mag;

    modport master (output valid, output bin, output mag, input ready);
    modport slave  (input valid, input bin, input mag, output ready);

endinterface

// File: rtl/fft_mag_est.sv
// Combinational magnitude estimate |re|+|im|, shared with the display path.
module fft_mag_est
    import fft_pkg::*;
(
    input  logic signed [DATA_W-1:0] re,
    input  logic signed [DATA_W-1:0] im,
    output logic        [DATA_W:0]   mag
);

    assign mag = abs_sum(re, im);

endmodule

// File: rtl/fft_frame_sched.sv
// Frame scheduler: latches capture frames, launches and supervises one FFT per frame,
// releases the capture buffer and streams the bin magnitudes out.
module fft_frame_sched
    import fft_pkg::*;
#(
    parameter int BIN_NUM     = fft_pkg::BIN_NUM,
    parameter int BIN_W       = fft_pkg::BIN_W,
    parameter int DATA_W      = fft_pkg::DATA_W,
    parameter int TIMEOUT_CYC = fft_pkg::TIMEOUT_CYC
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable_i,
    input  logic                     frame_new_i,
    output logic                     frame_ack_o,
    output logic                     fft_start_o,
    input  logic                     fft_loading_i,
    input  logic                     fft_done_i,
    output logic [BIN_W-1:0]         bin_addr_o,
    input  logic signed [DATA_W-1:0] bin_real_i,
    input  logic signed [DATA_W-1:0] bin_img_i,
    fft_frame_sched_if.master        ob,
    output logic                     busy_o,
    output logic                     err_timeout_o,
    output logic [7:0]               overrun_cnt_o
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    state_t           state;
    logic             pending;
    logic             load_seen;
    logic [BIN_W-1:0] k;
    logic [TMO_W-1:0] tmo_cnt;
    logic [DATA_W:0]  mag;
    logic             pend_take;
    logic             tmo_hit;

    fft_mag_est u_mag (
        .re  (bin_real_i),
        .im  (bin_img_i),
        .mag (mag)
    );

    assign pend_take = (state == IDLE) && pending && enable_i;
    // The counter starts one cycle after fft_start_o, so the limit is shifted by two
    // to raise the flag exactly TIMEOUT_CYC cycles after the start pulse.
    assign tmo_hit   = (tmo_cnt == TMO_W'(TIMEOUT_CYC - 2));

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            pending       <= 1'b0;
            load_seen     <= 1'b0;
            k             <= '0;
            tmo_cnt       <= '0;
            frame_ack_o   <= 1'b0;
            fft_start_o   <= 1'b0;
            bin_addr_o    <= '0;
            ob.valid      <= 1'b0;
            ob.bin        <= '0;
            ob.mag        <= '0;
            busy_o        <= 1'b0;
            err_timeout_o <= 1'b0;
            overrun_cnt_o <= '0;
        end else begin
            frame_ack_o <= 1'b0;
            fft_start_o <= 1'b0;

            // A new frame arriving while the pending one is consumed re-arms without overrun.
            if (pend_take) begin
                pending <= frame_new_i;
            end else if (frame_new_i) begin
                pending <= 1'b1;
                if (pending && overrun_cnt_o != 8'hFF)
                    overrun_cnt_o <= overrun_cnt_o + 8'd1;
            end

            case (state)
                IDLE: begin
                    if (pend_take) begin
                        state       <= START;
                        fft_start_o <= 1'b1;
                        busy_o      <= 1'b1;
                    end
                end
                START: begin
                    tmo_cnt   <= '0;
                    load_seen <= 1'b0;
                    state     <= LOAD;
                end
                LOAD: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (fft_done_i) begin
                        frame_ack_o <= 1'b1;
                        k           <= '0;
                        bin_addr_o  <= '0;
                        state       <= RD_ADDR;
                    end else if (tmo_hit) begin
                        err_timeout_o <= 1'b1;
                        frame_ack_o   <= 1'b1;
                        busy_o        <= 1'b0;
                        state         <= IDLE;
                    end else if (fft_loading_i) begin
                        load_seen <= 1'b1;
                    end else if (load_seen) begin
                        frame_ack_o <= 1'b1;
                        state       <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (fft_done_i) begin
                        k          <= '0;
                        bin_addr_o <= '0;
                        state      <= RD_ADDR;
                    end else if (tmo_hit) begin
                        err_timeout_o <= 1'b1;
                        busy_o        <= 1'b0;
                        state         <= IDLE;
                    end
                end
                RD_ADDR: state <= RD_DATA;
                RD_DATA: begin
                    ob.valid <= 1'b1;
                    ob.bin   <= k;
                    ob.mag   <= mag;
                    state    <= PRESENT;
                end
                PRESENT: begin
                    if (ob.ready) begin
                        ob.valid <= 1'b0;
                        if (k == BIN_W'(BIN_NUM - 1)) begin
                            busy_o <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            k          <= k + 1'b1;
                            bin_addr_o <= k + 1'b1;
                            state      <= RD_ADDR;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_frame_sched.sv
// Self-checking bench for fft_frame_sched: result-RAM model plus bin scoreboard.
module tb_fft_frame_sched;
    import fft_pkg::*;

    logic clk = 1'b0;
    logic rst, enable, frame_new, loading, done;
    logic ack, start, busy, err;
    logic [BIN_W-1:0] bin_addr;
    logic signed [DATA_W-1:0] bin_real, bin_img;
    logic [7:0] ovr;

    fft_frame_sched_if ob();

    fft_frame_sched dut (
        .clk           (clk),
        .rst           (rst),
        .enable_i      (enable),
        .frame_new_i   (frame_new),
        .frame_ack_o   (ack),
        .fft_start_o   (start),
        .fft_loading_i (loading),
        .fft_done_i    (done),
        .bin_addr_o    (bin_addr),
        .bin_real_i    (bin_real),
        .bin_img_i     (bin_img),
        .ob            (ob),
        .busy_o        (busy),
        .err_timeout_o (err),
        .overrun_cnt_o (ovr)
    );

    always #5 clk = ~clk;

    logic signed [DATA_W-1:0] ram_re [BIN_NUM];
    logic signed [DATA_W-1:0] ram_im [BIN_NUM];

    always @(posedge clk) begin
        bin_real <= ram_re[bin_addr];
        bin_img  <= ram_im[bin_addr];
    end

    int              q_bin [$];
    logic [DATA_W:0] q_mag [$];
    int n_checks = 0;
    int n_pass   = 0;

    function automatic logic [DATA_W:0] ref_mag(input logic signed [DATA_W-1:0] re,
                                                input logic signed [DATA_W-1:0] im);
        longint a, b;
        a = re;
        b = im;
        if (a < 0) a = -a;
        if (b < 0) b = -b;
        return (DATA_W+1)'(a + b);
    endfunction

    // Scoreboard pop on every accepted bin
    int              sb_bin;
    logic [DATA_W:0] sb_mag;
    always @(negedge clk) begin
        if (!rst && ob.valid && ob.ready) begin
            n_checks++;
            if (q_bin.size() == 0) begin
                $display("FAIL sb_extra: got bin %0d, no bin expected", ob.bin);
            end else begin
                sb_bin = q_bin.pop_front();
                sb_mag = q_mag.pop_front();
                if (ob.bin !== BIN_W'(sb_bin) || ob.mag !== sb_mag)
                    $display("FAIL sb_bin: got bin %0d mag %0d, expected bin %0d mag %0d",
                             ob.bin, ob.mag, sb_bin, sb_mag);
                else
                    n_pass++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_ram(input bit big);
        for (int i = 0; i < BIN_NUM; i++) begin
            if (big) begin
                ram_re[i] = $urandom;
                ram_im[i] = $urandom;
            end else begin
                ram_re[i] = int'($urandom_range(0, 200000)) - 100000;
                ram_im[i] = int'($urandom_range(0, 200000)) - 100000;
            end
        end
    endtask

    task automatic pulse_frame();
        frame_new = 1'b1;
        tick();
        frame_new = 1'b0;
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (start) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic do_load(input int n);
        loading = 1'b1;
        repeat (n) tick();
        loading = 1'b0;
    endtask

    task automatic do_done();
        for (int i = 0; i < BIN_NUM; i++) begin
            q_bin.push_back(i);
            q_mag.push_back(ref_mag(ram_re[i], ram_im[i]));
        end
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    task automatic drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            if (!busy && q_bin.size() == 0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; frame_new = 1'b0; loading = 1'b0; done = 1'b0;
        ob.ready = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({ack, start, ob.valid, busy, err} !== 5'b0)
            $display("FAIL reset_ctrl: got %b, expected 00000", {ack, start, ob.valid, busy, err});
        else n_pass++;
        n_checks++;
        if (bin_addr !== '0 || ob.bin !== '0)
            $display("FAIL reset_idx: got addr %0d bin %0d, expected 0 0", bin_addr, ob.bin);
        else n_pass++;
        n_checks++;
        if (ob.mag !== '0) $display("FAIL reset_mag: got %0d, expected 0", ob.mag);
        else n_pass++;
        n_checks++;
        if (ovr !== 8'd0) $display("FAIL reset_ovr: got %0d, expected 0", ovr);
        else n_pass++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_nominal();
        bit ok;
        enable = 1'b1;
        ob.ready = 1'b1;
        fill_ram(1'b0);
        ram_re[0] = -5;
        ram_im[0] = 7;
        pulse_frame();
        n_checks++;
        if (start !== 1'b0) $display("FAIL nom_start_t1: got %b, expected 0", start);
        else n_pass++;
        tick();
        n_checks++;
        if (start !== 1'b1) $display("FAIL nom_start_t2: got %b, expected 1", start);
        else n_pass++;
        tick();
        do_load(1024);
        n_checks++;
        if (ack !== 1'b0) $display("FAIL nom_ack_early: got %b, expected 0", ack);
        else n_pass++;
        tick();
        n_checks++;
        if (ack !== 1'b1) $display("FAIL nom_ack: got %b, expected 1", ack);
        else n_pass++;
        tick();
        n_checks++;
        if (ack !== 1'b0) $display("FAIL nom_ack_pulse: got %b, expected 0", ack);
        else n_pass++;
        repeat (498) tick();
        do_done();
        tick();
        n_checks++;
        if (ob.valid !== 1'b0) $display("FAIL nom_valid_d2: got %b, expected 0", ob.valid);
        else n_pass++;
        tick();
        n_checks++;
        if (ob.valid !== 1'b1 || ob.bin !== '0 || ob.mag !== 33'd12)
            $display("FAIL nom_first_bin: got v=%b bin=%0d mag=%0d, expected v=1 bin=0 mag=12",
                     ob.valid, ob.bin, ob.mag);
        else n_pass++;
        drain(ok);
        n_checks++;
        if (!ok) $display("FAIL nom_drain: %0d bins left, busy=%b, expected 0 left", q_bin.size(), busy);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        bit ok, corner_seen, pv, pr;
        logic [BIN_W-1:0] pb;
        logic [DATA_W:0]  pm;
        corner_seen = 1'b0; pv = 1'b0; pr = 1'b0; pb = '0; pm = '0;
        fill_ram(1'b1);
        ram_re[3] = 32'sh8000_0000;
        ram_im[3] = 32'sh8000_0000;
        pulse_frame();
        wait_start(ok);
        n_checks++;
        if (!ok) $display("FAIL bp_start: no fft_start, expected one");
        else n_pass++;
        tick();
        do_load(20);
        repeat (10) tick();
        do_done();
        ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            if (!busy && q_bin.size() == 0) begin
                ok = 1'b1;
                break;
            end
            if (pv && !pr) begin
                n_checks++;
                if (ob.valid !== 1'b1 || ob.bin !== pb || ob.mag !== pm)
                    $display("FAIL bp_hold: got v=%b bin=%0d mag=%0d, expected v=1 bin=%0d mag=%0d",
                             ob.valid, ob.bin, ob.mag, pb, pm);
                else n_pass++;
            end
            if (ob.valid && ob.bin == 3 && !corner_seen) begin
                corner_seen = 1'b1;
                n_checks++;
                if (ob.mag !== 33'h1_0000_0000)
                    $display("FAIL bp_corner: got %0d, expected 4294967296", ob.mag);
                else n_pass++;
            end
            ob.ready = 1'($urandom_range(0, 1));
            pv = ob.valid; pr = ob.ready; pb = ob.bin; pm = ob.mag;
            tick();
        end
        n_checks++;
        if (!ok || !corner_seen)
            $display("FAIL bp_drain: %0d bins left, corner_seen=%b, expected 0 and 1", q_bin.size(), corner_seen);
        else n_pass++;
        ob.ready = 1'b1;
    endtask

    task automatic test_enable();
        bit ok, bad;
        enable = 1'b0;
        bad = 1'b0;
        pulse_frame();
        repeat (10) begin
            if (busy || start) bad = 1'b1;
            tick();
        end
        n_checks++;
        if (bad) $display("FAIL en_blocked: busy/start seen=1, expected 0");
        else n_pass++;
        enable = 1'b1;
        tick();
        n_checks++;
        if (start !== 1'b1) $display("FAIL en_start: got %b, expected 1", start);
        else n_pass++;
        tick();
        fill_ram(1'b0);
        do_load(20);
        repeat (5) tick();
        do_done();
        drain(ok);
        n_checks++;
        if (!ok) $display("FAIL en_drain: %0d bins left, expected 0", q_bin.size());
        else n_pass++;
    endtask

    task automatic test_overrun();
        bit ok;
        int starts;
        fill_ram(1'b0);
        pulse_frame();
        wait_start(ok);
        tick();
        do_load(20);
        repeat (2) tick();
        repeat (3) begin
            pulse_frame();
            tick();
        end
        n_checks++;
        if (ovr !== 8'd2) $display("FAIL ovr_count: got %0d, expected 2", ovr);
        else n_pass++;
        repeat (5) tick();
        do_done();
        drain(ok);
        starts = 0;
        repeat (20) begin
            if (start) starts++;
            tick();
        end
        n_checks++;
        if (!ok || starts != 1) $display("FAIL ovr_relaunch: got %0d starts, drained=%b, expected 1 and 1", starts, ok);
        else n_pass++;
        do_load(20);
        tick();
        do_done();
        drain(ok);
        starts = 0;
        repeat (20) begin
            if (start) starts++;
            tick();
        end
        n_checks++;
        if (!ok || starts != 0) $display("FAIL ovr_no_extra: got %0d starts, drained=%b, expected 0 and 1", starts, ok);
        else n_pass++;
        enable = 1'b0;
        repeat (300) begin
            pulse_frame();
            tick();
        end
        n_checks++;
        if (ovr !== 8'd255) $display("FAIL ovr_sat: got %0d, expected 255", ovr);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit ok, hit;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        enable = 1'b1;
        tick();
        fill_ram(1'b0);
        pulse_frame();
        wait_start(ok);
        tick();
        do_load(20);
        repeat (3) tick();
        do_done();
        hit = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (ob.valid && ob.bin == 100) begin
                hit = 1'b1;
                break;
            end
            tick();
        end
        n_checks++;
        if (!hit) $display("FAIL rm_reach: bin 100 not presented, expected it");
        else n_pass++;
        rst = 1'b1;
        tick();
        n_checks++;
        if ({ack, start, ob.valid, busy, err} !== 5'b0)
            $display("FAIL rm_ctrl: got %b, expected 00000", {ack, start, ob.valid, busy, err});
        else n_pass++;
        n_checks++;
        if (bin_addr !== '0 || ob.bin !== '0 || ob.mag !== '0 || ovr !== 8'd0)
            $display("FAIL rm_data: got addr=%0d bin=%0d mag=%0d ovr=%0d, expected all 0",
                     bin_addr, ob.bin, ob.mag, ovr);
        else n_pass++;
        q_bin.delete();
        q_mag.delete();
        rst = 1'b0;
        tick();
        fill_ram(1'b0);
        pulse_frame();
        wait_start(ok);
        tick();
        do_load(20);
        repeat (3) tick();
        do_done();
        tick();
        tick();
        n_checks++;
        if (ob.valid !== 1'b1 || ob.bin !== '0)
            $display("FAIL rm_restart: got v=%b bin=%0d, expected v=1 bin=0", ob.valid, ob.bin);
        else n_pass++;
        drain(ok);
        n_checks++;
        if (!ok) $display("FAIL rm_drain: %0d bins left, expected 0", q_bin.size());
        else n_pass++;
    endtask

    task automatic test_timeout();
        bit ok, seen_valid;
        int acks;
        acks = 0;
        seen_valid = 1'b0;
        pulse_frame();
        wait_start(ok);
        n_checks++;
        if (!ok) $display("FAIL tmo_start: no fft_start, expected one");
        else n_pass++;
        for (int j = 1; j <= TIMEOUT_CYC; j++) begin
            tick();
            if (j == 1) loading = 1'b1;
            if (j == 11) loading = 1'b0;
            if (ack) acks++;
            if (ob.valid) seen_valid = 1'b1;
            if (j == TIMEOUT_CYC - 1) begin
                n_checks++;
                if (err !== 1'b0 || busy !== 1'b1)
                    $display("FAIL tmo_before: got err=%b busy=%b, expected 0 1", err, busy);
                else n_pass++;
            end
            if (j == TIMEOUT_CYC) begin
                n_checks++;
                if (err !== 1'b1 || busy !== 1'b0)
                    $display("FAIL tmo_flag: got err=%b busy=%b, expected 1 0", err, busy);
                else n_pass++;
            end
        end
        n_checks++;
        if (acks != 1 || seen_valid)
            $display("FAIL tmo_outputs: got %0d acks valid_seen=%b, expected 1 and 0", acks, seen_valid);
        else n_pass++;
        fill_ram(1'b0);
        pulse_frame();
        wait_start(ok);
        tick();
        do_load(20);
        repeat (3) tick();
        do_done();
        drain(ok);
        n_checks++;
        if (!ok || err !== 1'b1)
            $display("FAIL tmo_sticky: got err=%b drained=%b, expected 1 1", err, ok);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_enable();
        test_overrun();
        test_reset_mid();
        test_timeout();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
